mul_dispatch: RTL and testbench

//  Upstream issue stage for the 16-bit shift-add multiplier (muler). Buffers operand

---
 rtl/mul_dispatch.sv | 126 ++++++++++++
 tb/tb_mul_dispatch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_dispatch.sv
// Issue stage for the 16-bit shift-add multiplier: operand FIFO, load/complete tracking
// via the multiplier's busy flag, and an in-order valid/ready result port. Option: MUL_ZERO_BYPASS_EN.
module mul_dispatch #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] mul_in1,
  output logic [WIDTH-1:0] mul_in2,
  input  logic [WIDTH-1:0] mul_out,
  input  logic             mul_busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW:0]      fifo_count,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens at a posedge where valid && ready; the sender holds
  // valid and data stable until that edge, and ready may depend combinationally on state.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop, issue, capture, bypass;
  logic [WIDTH-1:0] head_a, head_b;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign req_ready  = !full && !RST;
  assign push       = req_valid && req_ready;
  assign head_a     = mem_a[rd_ptr];
  assign head_b     = mem_b[rd_ptr];
  assign fifo_count = count;
  assign fsm_state  = state;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    issue    = 1'b0;
    capture  = 1'b0;
    bypass   = 1'b0;
    case (state)
      IDLE: begin
        // A held result blocks the next pop so responses never overtake each other.
        if (!empty && !rsp_valid) begin
          pop = 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
          if (head_a == '0 || head_b == '0) begin
            bypass = 1'b1;
          end else begin
            issue    = 1'b1;
            state_nx = LOAD;
          end
`else
          issue    = 1'b1;
          state_nx = LOAD;
`endif
        end
      end
      LOAD: begin
        if (!mul_busy) state_nx = WAIT;
      end
      WAIT: begin
        if (!mul_busy) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Storage needs no reset: only entries behind the pointers are ever read.
  always_ff @(posedge CK) begin
    if (push) begin
      mem_a[wr_ptr] <= req_a;
      mem_b[wr_ptr] <= req_b;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mul_in1   <= '0;
      mul_in2   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (issue) begin
        mul_in1 <= head_a;
        mul_in2 <= head_b;
      end
      if (capture) begin
        rsp_data  <= mul_out;
        rsp_valid <= 1'b1;
      end else if (bypass) begin
        rsp_data  <= '0;
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_dispatch.sv
// Testbench for mul_dispatch with a behavioural shift-add multiplier model that
// reloads whenever idle and stays busy for (MSB index of b) cycles.
module tb_mul_dispatch;

  logic        CK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, mul_busy;
  logic [15:0] req_a, req_b, mul_in1, mul_in2, mul_out, rsp_data;
  logic [2:0]  fifo_count;
  logic [1:0]  fsm_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 CK = ~CK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mul_dispatch #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
    .CK(CK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out), .mul_busy(mul_busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .fifo_count(fifo_count), .fsm_state(fsm_state)
  );

  // ---------------- multiplier model (no reset) ----------------
  logic [4:0]  m_cnt  = '0;
  logic [15:0] m_prod = '0;
  initial mul_out = '0;
  assign mul_busy = (m_cnt != 0);

  function automatic int msb_idx(input logic [15:0] v);
    int r = 0;
    for (int i = 0; i < 16; i++) if (v[i] === 1'b1) r = i;
    return r;
  endfunction

  always @(posedge CK) begin
    if (m_cnt == 0) begin
      m_prod  <= mul_in1 * mul_in2;
      m_cnt   <= 5'(msb_idx(mul_in2));
      mul_out <= (msb_idx(mul_in2) == 0) ? mul_in1 * mul_in2 : 16'hDEAD;
    end else begin
      m_cnt <= m_cnt - 5'd1;
      if (m_cnt == 5'd1) mul_out <= m_prod;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One isolated operation: called at posedge+1 with the DUT idle and the result slot free.
  // stall = busy cycles the multiplier model still has at the DUT's load edge.
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input int base_lat, input bit uses_mul);
    int lat, stall, want;
    req_valid = 1'b1; req_a = a; req_b = b;
    check({name, " ready"}, req_ready, 1);
    @(posedge CK); #1;                  // E0: accept
    req_valid = 1'b0;
    @(posedge CK); #1;                  // E1: pop
    stall = m_cnt;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge CK); #1;
      lat++;
    end
    want = uses_mul ? base_lat + stall : base_lat;
    check({name, " latency"}, lat, want);
    check({name, " data"}, rsp_data, exp);
    if (uses_mul) check({name, " mul_in1"}, mul_in1, a);
    @(posedge CK); #1;
    check({name, " one-cycle"}, rsp_valid, 0);
  endtask

  // One clock of the streaming phase: drive, sample both handshakes at negedge, advance.
  task automatic step(input bit drive, input logic [15:0] a, input logic [15:0] b,
                      output bit acc, output bit hs, output logic [15:0] hs_data);
    req_valid = drive; req_a = a; req_b = b;
    @(negedge CK);
    acc     = req_valid && req_ready;
    hs      = rsp_valid && rsp_ready;
    hs_data = rsp_data;
    @(posedge CK); #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    int          base_lat;   // accept-to-rsp_valid cycles with an idle multiplier
    bit          uses_mul;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit          acc, hs;
    logic [15:0] d;
    logic [15:0] pa [8];
    logic [15:0] pb [8];
    int          idx, got, extra, cyc;

    vecs[0] = '{16'd3,    16'd5,    16'd15,   5,  1'b1};
    vecs[1] = '{16'hFFFF, 16'd2,    16'hFFFE, 4,  1'b1};
    vecs[2] = '{16'h0100, 16'h0100, 16'h0000, 11, 1'b1};
    vecs[3] = '{16'd7,    16'd1,    16'd7,    3,  1'b1};
    vecs[4] = '{16'h00FF, 16'h00FF, 16'hFE01, 10, 1'b1};
    vecs[5] = '{16'h1234, 16'h0003, 16'h369C, 4,  1'b1};
`ifdef MUL_ZERO_BYPASS_EN
    vecs[6] = '{16'd0,    16'h8000, 16'h0000, 1,  1'b0};
    vecs[7] = '{16'd9,    16'd0,    16'h0000, 1,  1'b0};
`else
    vecs[6] = '{16'd0,    16'h8000, 16'h0000, 18, 1'b1};
    vecs[7] = '{16'd9,    16'd0,    16'h0000, 3,  1'b1};
`endif

    RST = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // Reset held two cycles
    repeat (2) @(posedge CK);
    #1;
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_data", rsp_data, 0);
    check("rst mul_in1", mul_in1, 0);
    check("rst mul_in2", mul_in2, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst req_ready low", req_ready, 0);
    RST = 1'b0;
    #1;
    check("req_ready after rst", req_ready, 1);
    @(posedge CK); #1;

    // Table of isolated operations
    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp,
            vecs[i].base_lat, vecs[i].uses_mul);

    // Back-pressure: six requests with the result port stalled
    for (int i = 0; i < 8; i++) begin
      pa[i] = 16'(2 * i + 2);
      pb[i] = 16'(2 * i + 3);
    end
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      step(idx < 6, pa[idx], pb[idx], acc, hs, d);
      if (acc) begin
        exp_q.push_back(16'(pa[idx] * pb[idx]));
        idx++;
      end
    end
    check("bp accepted", idx, 5);
    check("bp fifo_count", fifo_count, 4);
    check("bp req_ready", req_ready, 0);
    check("bp rsp_valid", rsp_valid, 1);
    check("bp rsp_data", rsp_data, 6);
    repeat (5) step(idx < 6, pa[idx], pb[idx], acc, hs, d);
    check("bp hold rsp_valid", rsp_valid, 1);
    check("bp hold rsp_data", rsp_data, 6);
    check("bp hold fifo_count", fifo_count, 4);

    rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 400) begin
      step(idx < 6, pa[idx], pb[idx], acc, hs, d);
      cyc++;
      if (acc) begin
        exp_q.push_back(16'(pa[idx] * pb[idx]));
        idx++;
      end
      if (hs) begin
        if (exp_q.size() == 0) check($sformatf("bp unexpected rsp%0d", got), d, 16'hFFFF);
        else check($sformatf("bp order rsp%0d", got), d, exp_q.pop_front());
        got++;
      end
    end
    extra = 0;
    repeat (30) begin
      step(1'b0, 16'd0, 16'd0, acc, hs, d);
      if (hs) extra++;
    end
    check("bp responses", got, 6);
    check("bp duplicates", extra, 0);
    check("bp all pushed", idx, 6);
    check("bp drained", fifo_count, 0);

    // Reset in the middle of a long run, then issue while the multiplier is still busy
    req_valid = 1'b1; req_a = 16'd1; req_b = 16'h8000;
    @(posedge CK); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (fsm_state != 2'd2 && cyc < 40) begin
      @(posedge CK); #1;
      cyc++;
    end
    check("reach WAIT", (cyc < 40), 1);
    repeat (3) @(posedge CK);
    #1;
    RST = 1'b1;
    @(posedge CK); #1;
    RST = 1'b0;
    check("mid-rst rsp_valid", rsp_valid, 0);
    check("mid-rst fifo_count", fifo_count, 0);
    check("mid-rst state", fsm_state, 0);
    extra = 0;
    repeat (3) begin
      @(posedge CK); #1;
      if (rsp_valid) extra++;
    end
    check("mid-rst no response", extra, 0);
    do_op("after rst", 16'd2, 16'd3, 16'd6, 4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
